// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage and its neighbours.
// Holds the datapath widths, the "no register" index, the bubble control
// value and the packed EX-side bundle that the EX/MEM stage also reuses.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    localparam logic [REG_AW-1:0] REG_ZERO    = '0;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef struct packed {
        logic              valid;
        logic              reg_wen;
        logic              mem_read;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    // A bubble carries no work and zero indices, so it can never match a
    // source in the forwarding unit.
    function automatic id_ex_t bubble();
        id_ex_t b;
        b      = '0;
        b.ctrl = CTRL_BUBBLE;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between decode/writeback and the ID/EX pipeline register.
// master: the upstream side that drives decode, writeback and control.
// slave : the ID/EX stage itself, which returns stall_out and the EX fields.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_reg_wen;
    logic              id_mem_read;
    logic              id_uses_rt;

    logic              wb_wen;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              flush;
    logic              freeze;

    logic              stall_out;
    logic              ex_valid;
    logic              ex_reg_wen;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_ctrl, id_reg_wen, id_mem_read, id_uses_rt,
               wb_wen, wb_rd, wb_data, flush, freeze,
        input  stall_out, ex_valid, ex_reg_wen, ex_mem_read, ex_rs, ex_rt,
               ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_ctrl
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_ctrl, id_reg_wen, id_mem_read, id_uses_rt,
               wb_wen, wb_rd, wb_data, flush, freeze,
        output stall_out, ex_valid, ex_reg_wen, ex_mem_read, ex_rs, ex_rt,
               ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_ctrl
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection for the ID/EX stage.
// A load sitting in EX whose destination is a real register read by the
// decode instruction forces one bubble; the stall request itself is
// suppressed while the slot is flushed, the pipe is frozen or in reset.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic              i_rst,
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_flush,
    input  logic              i_freeze,
    output logic              o_load_use,
    output logic              o_stall
);

    // Raw hazard plus the stall request qualified by the higher-priority events
    always_comb begin
        o_load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd != REG_ZERO) & i_id_valid &
                     ((i_ex_rd == i_id_rs) | (i_id_uses_rt & (i_ex_rd == i_id_rt)));
        o_stall    = o_load_use & ~i_flush & ~i_freeze & ~i_rst;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Captures decode results for EX, applies WB-to-ID write-through on the
// operand data, inserts a bubble on flush or load-use, and holds on freeze.
// Optional build macro ID_EX_STALL_CNT_EN adds a free-running 32-bit count
// of load-use stall cycles on port o_stall_cnt.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]  o_stall_cnt
`endif
);

    id_ex_t            r_ex;
    id_ex_t            w_id_entry;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_load_use;
    logic              w_stall;

    id_ex_stage_hazard_detect u_hazard (
        .i_rst         (rst),
        .i_ex_valid    (r_ex.valid),
        .i_ex_mem_read (r_ex.mem_read),
        .i_ex_rd       (r_ex.rd),
        .i_id_valid    (bus.id_valid),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_flush       (bus.flush),
        .i_freeze      (bus.freeze),
        .o_load_use    (w_load_use),
        .o_stall       (w_stall)
    );

    // Write-through bypass and assembly of the entry decode would hand to EX
    always_comb begin
        w_rs_data = bus.id_rs_data;
        w_rt_data = bus.id_rt_data;
        if (bus.wb_wen && (bus.wb_rd != REG_ZERO) && (bus.wb_rd == bus.id_rs)) begin
            w_rs_data = bus.wb_data;
        end
        if (bus.wb_wen && (bus.wb_rd != REG_ZERO) && (bus.wb_rd == bus.id_rt)) begin
            w_rt_data = bus.wb_data;
        end

        w_id_entry          = '0;
        w_id_entry.valid    = bus.id_valid;
        w_id_entry.reg_wen  = bus.id_reg_wen & bus.id_valid;
        w_id_entry.mem_read = bus.id_mem_read & bus.id_valid;
        w_id_entry.rs       = bus.id_rs;
        w_id_entry.rt       = bus.id_rt;
        w_id_entry.rd       = bus.id_rd;
        w_id_entry.rs_data  = w_rs_data;
        w_id_entry.rt_data  = w_rt_data;
        w_id_entry.imm      = bus.id_imm;
        w_id_entry.ctrl     = bus.id_ctrl;
    end

    // Pipeline register: reset, then freeze hold, then bubble, then load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= bubble();
        end else if (bus.freeze) begin
            r_ex <= r_ex;
        end else if (bus.flush || w_load_use) begin
            r_ex <= bubble();
        end else begin
            r_ex <= w_id_entry;
        end
    end

    assign bus.stall_out   = w_stall;
    assign bus.ex_valid    = r_ex.valid;
    assign bus.ex_reg_wen  = r_ex.reg_wen;
    assign bus.ex_mem_read = r_ex.mem_read;
    assign bus.ex_rs       = r_ex.rs;
    assign bus.ex_rt       = r_ex.rt;
    assign bus.ex_rd       = r_ex.rd;
    assign bus.ex_rs_data  = r_ex.rs_data;
    assign bus.ex_rt_data  = r_ex.rt_data;
    assign bus.ex_imm      = r_ex.imm;
    assign bus.ex_ctrl     = r_ex.ctrl;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count every cycle in which PC and IF/ID were held for a load-use hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the EX slot.
// Build with ID_EX_STALL_CNT_EN defined to also exercise the stall counter.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stallCnt;
`endif

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .o_stall_cnt (stallCnt)
`endif
    );

    int totalChecks = 0;
    int badChecks   = 0;

    // Behavioural view of the instruction currently sitting in EX
    logic        mValid, mRegWen, mMemRead;
    logic [4:0]  mRs, mRt, mRd;
    logic [31:0] mRsData, mRtData, mImm;
    logic [7:0]  mCtrl;
    logic [31:0] mStallCnt;
    logic        lastStall;

    // Compare one observed value with its expected value and log a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // EX slot becomes empty
    task automatic modelEmpty();
        mValid = 0; mRegWen = 0; mMemRead = 0;
        mRs = 0; mRt = 0; mRd = 0;
        mRsData = 0; mRtData = 0; mImm = 0; mCtrl = 0;
    endtask

    // The value a source register really holds once the WB write lands
    function automatic logic [31:0] freshValue(input logic [4:0] idx, input logic [31:0] rfValue);
        if (bus.wb_wen && idx != 0 && idx == bus.wb_rd) return bus.wb_data;
        return rfValue;
    endfunction

    // Decode reads a real register that a load in EX has not produced yet
    function automatic bit decodeNeedsLoadResult();
        bit readsRs, readsRt;
        if (!(mValid && mMemRead) || mRd == 0 || !bus.id_valid) return 0;
        readsRs = (bus.id_rs == mRd);
        readsRt = bus.id_uses_rt && (bus.id_rt == mRd);
        return readsRs || readsRt;
    endfunction

    // One clock: check stall mid-cycle, advance the model, check EX after the edge
    task automatic applyStimulus();
        bit hazard, expStall;
        @(negedge clk);
        hazard   = decodeNeedsLoadResult();
        expStall = hazard && !bus.flush && !bus.freeze && !rst;
        lastStall = bus.stall_out;
        checkOutput("stall_out", 32'(bus.stall_out), 32'(expStall));

        if (rst) begin
            modelEmpty();
            mStallCnt = 0;
        end else begin
            if (expStall) mStallCnt = mStallCnt + 1;
            if (bus.freeze) begin
                // nothing moves
            end else if (bus.flush || hazard) begin
                modelEmpty();
            end else begin
                mValid   = bus.id_valid;
                mRegWen  = bus.id_valid && bus.id_reg_wen;
                mMemRead = bus.id_valid && bus.id_mem_read;
                mRs      = bus.id_rs;
                mRt      = bus.id_rt;
                mRd      = bus.id_rd;
                mRsData  = freshValue(bus.id_rs, bus.id_rs_data);
                mRtData  = freshValue(bus.id_rt, bus.id_rt_data);
                mImm     = bus.id_imm;
                mCtrl    = bus.id_ctrl;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("ex_valid",    32'(bus.ex_valid),    32'(mValid));
        checkOutput("ex_reg_wen",  32'(bus.ex_reg_wen),  32'(mRegWen));
        checkOutput("ex_mem_read", 32'(bus.ex_mem_read), 32'(mMemRead));
        checkOutput("ex_rs",       32'(bus.ex_rs),       32'(mRs));
        checkOutput("ex_rt",       32'(bus.ex_rt),       32'(mRt));
        checkOutput("ex_rd",       32'(bus.ex_rd),       32'(mRd));
        checkOutput("ex_rs_data",  bus.ex_rs_data,       mRsData);
        checkOutput("ex_rt_data",  bus.ex_rt_data,       mRtData);
        checkOutput("ex_imm",      bus.ex_imm,           mImm);
        checkOutput("ex_ctrl",     32'(bus.ex_ctrl),     32'(mCtrl));
`ifdef ID_EX_STALL_CNT_EN
        checkOutput("stall_cnt",   stallCnt,             mStallCnt);
`endif
    endtask

    // Quiet inputs: no instruction, no writeback, no control events
    task automatic setIdle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_ctrl = 0;
        bus.id_reg_wen = 0; bus.id_mem_read = 0; bus.id_uses_rt = 0;
        bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.flush = 0; bus.freeze = 0;
    endtask

    // A valid decode instruction with random payload
    task automatic setInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic isLoad, input logic usesRt);
        setIdle();
        bus.id_valid    = 1;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_rs_data  = $urandom;
        bus.id_rt_data  = $urandom;
        bus.id_imm      = $urandom;
        bus.id_ctrl     = 8'($urandom);
        bus.id_reg_wen  = 1;
        bus.id_mem_read = isLoad;
        bus.id_uses_rt  = usesRt;
    endtask

    // Random traffic on a small register window so hazards and bypasses are common
    task automatic randomInputs();
        bus.id_valid    = ($urandom_range(0, 9) != 0);
        bus.id_rs       = 5'($urandom_range(0, 7));
        bus.id_rt       = 5'($urandom_range(0, 7));
        bus.id_rd       = 5'($urandom_range(0, 7));
        bus.id_rs_data  = $urandom;
        bus.id_rt_data  = $urandom;
        bus.id_imm      = $urandom;
        bus.id_ctrl     = 8'($urandom);
        bus.id_reg_wen  = 1'($urandom);
        bus.id_mem_read = ($urandom_range(0, 4) < 2);
        bus.id_uses_rt  = 1'($urandom);
        bus.wb_wen      = 1'($urandom);
        bus.wb_rd       = 5'($urandom_range(0, 7));
        bus.wb_data     = $urandom;
        bus.flush       = ($urandom_range(0, 9) == 0);
        bus.freeze      = ($urandom_range(0, 9) == 0);
    endtask

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then random traffic, then the summary
    initial begin
        modelEmpty();
        mStallCnt = 0;
        lastStall = 0;
        setIdle();

        $display("[TB] reset with live decode");
        rst = 1;
        setInstr(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 0, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("rst_stall", 32'(lastStall), 32'd0);
        rst = 0;
        applyStimulus();
        checkOutput("rel_valid", 32'(bus.ex_valid), 32'd1);

        $display("[TB] load-use bubble");
        setIdle();            applyStimulus();
        setInstr(1, 2, 5, 1, 1); applyStimulus();
        setInstr(5, 6, 9, 0, 1); applyStimulus();
        checkOutput("lu_stall", 32'(lastStall), 32'd1);
        checkOutput("lu_bubble", 32'(bus.ex_valid), 32'd0);
        applyStimulus();
        checkOutput("lu_once", 32'(lastStall), 32'd0);
        checkOutput("lu_rs", 32'(bus.ex_rs), 32'd5);
        checkOutput("lu_valid", 32'(bus.ex_valid), 32'd1);

        $display("[TB] non-hazards");
        setInstr(1, 2, 5, 1, 1); applyStimulus();
        setInstr(3, 5, 9, 0, 0); applyStimulus();
        checkOutput("nohaz_rt", 32'(lastStall), 32'd0);
        setInstr(1, 2, 0, 1, 1); applyStimulus();
        setInstr(0, 0, 9, 0, 1); applyStimulus();
        checkOutput("nohaz_r0", 32'(lastStall), 32'd0);

        $display("[TB] write-through");
        setInstr(7, 3, 9, 0, 1);
        bus.id_rs_data = 32'h1;
        bus.wb_wen = 1; bus.wb_rd = 7; bus.wb_data = 32'hDEAD_BEEF;
        applyStimulus();
        checkOutput("wt_hit", bus.ex_rs_data, 32'hDEAD_BEEF);
        bus.wb_rd = 0;
        applyStimulus();
        checkOutput("wt_r0", bus.ex_rs_data, 32'h1);

        $display("[TB] flush beats load-use");
        setInstr(1, 2, 5, 1, 1); applyStimulus();
        setInstr(5, 6, 9, 0, 1); bus.flush = 1; applyStimulus();
        checkOutput("fl_stall", 32'(lastStall), 32'd0);
        checkOutput("fl_valid", 32'(bus.ex_valid), 32'd0);

        $display("[TB] freeze holds, hazard resumes");
        setInstr(1, 2, 5, 1, 1); applyStimulus();
        setInstr(5, 6, 9, 0, 1); bus.freeze = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("fz_stall", 32'(lastStall), 32'd0);
            checkOutput("fz_rd", 32'(bus.ex_rd), 32'd5);
            checkOutput("fz_load", 32'(bus.ex_mem_read), 32'd1);
        end
        bus.freeze = 0;
        applyStimulus();
        checkOutput("fz_resume", 32'(lastStall), 32'd1);

`ifdef ID_EX_STALL_CNT_EN
        $display("[TB] stall counter");
        setIdle(); rst = 1; applyStimulus(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            setIdle();               applyStimulus();
            setInstr(1, 2, 5, 1, 1); applyStimulus();
            setInstr(5, 6, 9, 0, 1); applyStimulus();
            setIdle();               applyStimulus();
        end
        checkOutput("cnt_three", stallCnt, 32'd3);
        rst = 1; applyStimulus(); rst = 0;
        checkOutput("cnt_rst", stallCnt, 32'd0);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            randomInputs();
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
